sar_adc_ctrl: RTL and testbench

Digital successive-approximation controller for an on-chip ADC. It is the capture-direction counterpart of the core-to-DAC output path.
- Drives a 10-bit feedback DAC code (an avsddac instance) and a sample/hold strobe.
- Reads a 1-bit analog comparator decision and resolves one bit per step, MSB first.
- Delivers each finished sample to rvmyth over a valid/ready handshake.
- Clocked from the PLL output CLK in the SoC top.

---
 rtl/sar_adc_pkg.sv | 17 +
 rtl/sar_adc_ctrl_if.sv | 23 ++
 rtl/sar_cmp_sync.sv | 20 ++
 rtl/sar_adc_ctrl.sv | 145 ++++++++++++++
 tb/tb_sar_adc_ctrl.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/sar_adc_pkg.sv
// Shared types and defaults for the SAR ADC capture controller.
package sar_adc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SAMPLE,
        SETTLE,
        DECIDE,
        DONE
    } state_t;

    localparam int N_BITS_DEF        = 10;
    localparam int SAMPLE_CYCLES_DEF = 4;
    localparam int SETTLE_CYCLES_DEF = 2;
    localparam int SYNC_DEPTH        = 2;

endpackage

// File: rtl/sar_adc_ctrl_if.sv
// Controller-side bundle: start/busy, analog front-end strobes and the sample handshake.
interface sar_adc_ctrl_if #(
    parameter int N_BITS = sar_adc_pkg::N_BITS_DEF
);
    logic              start;
    logic              busy;
    logic              sample_hold;
    logic [N_BITS-1:0] dac_code;
    logic              cmp;
    logic [N_BITS-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output start, cmp, out_ready,
        input  busy, sample_hold, dac_code, out_data, out_valid
    );

    modport slave (
        input  start, cmp, out_ready,
        output busy, sample_hold, dac_code, out_data, out_valid
    );
endinterface

// File: rtl/sar_cmp_sync.sv
// Multi-flop synchronizer for the asynchronous comparator decision.
module sar_cmp_sync
    import sar_adc_pkg::*;
#(
    parameter int DEPTH = SYNC_DEPTH
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sync_pipe;

    always_ff @(posedge clk) begin
        if (!reset) sync_pipe <= '0;
        else        sync_pipe <= {sync_pipe[DEPTH-2:0], d};
    end

    assign q = sync_pipe[DEPTH-1];
endmodule

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: sample, then resolve one bit per trial, MSB first.
// Optional build macro SAR_CMP_SYNC_EN adds a comparator synchronizer and lengthens each settle.
module sar_adc_ctrl
    import sar_adc_pkg::*;
#(
    parameter int N_BITS        = N_BITS_DEF,
    parameter int SAMPLE_CYCLES = SAMPLE_CYCLES_DEF,
    parameter int SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
    input  logic          clk,
    input  logic          reset,
    sar_adc_ctrl_if.slave bus
);
    logic cmp_use;

`ifdef SAR_CMP_SYNC_EN
    // Settle is stretched by the synchronizer depth so DECIDE sees the current trial.
    localparam int SETTLE_LEN = SETTLE_CYCLES + SYNC_DEPTH;
    sar_cmp_sync #(.DEPTH(SYNC_DEPTH)) u_cmp_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.cmp),
        .q     (cmp_use)
    );
`else
    localparam int SETTLE_LEN = SETTLE_CYCLES;
    assign cmp_use = bus.cmp;
`endif

    localparam int IDX_W   = $clog2(N_BITS);
    localparam int CNT_MAX = (SAMPLE_CYCLES > SETTLE_LEN) ? SAMPLE_CYCLES : SETTLE_LEN;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SAMPLE_LAST = CNT_W'(SAMPLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((SETTLE_LEN > 0) ? SETTLE_LEN - 1 : 0);

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic [IDX_W-1:0]  idx, idx_n;
    logic [N_BITS-1:0] result, result_n;
    logic [N_BITS-1:0] dac_q, dac_n;
    logic [N_BITS-1:0] data_q, data_n;
    logic              sh_q, sh_n;
    logic              valid_q, valid_n;
    logic              busy_q, busy_n;
    logic [N_BITS-1:0] bit_mask, res_dec;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            idx     <= '0;
            result  <= '0;
            dac_q   <= '0;
            data_q  <= '0;
            sh_q    <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            idx     <= idx_n;
            result  <= result_n;
            dac_q   <= dac_n;
            data_q  <= data_n;
            sh_q    <= sh_n;
            valid_q <= valid_n;
            busy_q  <= busy_n;
        end
    end

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        idx_n    = idx;
        result_n = result;
        dac_n    = dac_q;
        data_n   = data_q;
        sh_n     = sh_q;
        valid_n  = valid_q;
        bit_mask = N_BITS'(1) << idx;
        res_dec  = cmp_use ? (result | bit_mask) : (result & ~bit_mask);

        unique case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n  = SAMPLE;
                    sh_n     = 1'b1;
                    dac_n    = '0;
                    result_n = '0;
                    idx_n    = IDX_W'(N_BITS - 1);
                    cnt_n    = '0;
                end
            end
            SAMPLE: begin
                if (cnt == SAMPLE_LAST) begin
                    sh_n  = 1'b0;
                    dac_n = result | bit_mask;
                    cnt_n = '0;
                    if (SETTLE_LEN > 0) state_n = SETTLE;
                    else                state_n = DECIDE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_n   = '0;
                    state_n = DECIDE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DECIDE: begin
                result_n = res_dec;
                if (idx != '0) begin
                    idx_n = idx - 1'b1;
                    dac_n = res_dec | (bit_mask >> 1);
                    if (SETTLE_LEN > 0) state_n = SETTLE;
                    else                state_n = DECIDE;
                end else begin
                    data_n  = res_dec;
                    valid_n = 1'b1;
                    dac_n   = '0;
                    state_n = DONE;
                end
            end
            DONE: begin
                // start is deliberately not looked at here, even on the handshake edge.
                if (valid_q && bus.out_ready) begin
                    valid_n = 1'b0;
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase

        busy_n = (state_n != IDLE);
    end

    assign bus.busy        = busy_q;
    assign bus.sample_hold = sh_q;
    assign bus.dac_code    = dac_q;
    assign bus.out_data    = data_q;
    assign bus.out_valid   = valid_q;
endmodule

// File: tb/tb_sar_adc_ctrl.sv
// Bench: two controllers (default settle, zero settle) against a cycle-level conversion model.
module tb_sar_adc_ctrl;
    localparam int N    = 10;
    localparam int S    = 4;
    localparam int SET0 = 2;
    localparam int SET1 = 0;
`ifdef SAR_CMP_SYNC_EN
    localparam int SYNCX   = 2;
    localparam int LAT_LIT = 54;
`else
    localparam int SYNCX   = 0;
    localparam int LAT_LIT = 34;
`endif
    localparam int P0   = SET0 + SYNCX + 1;
    localparam int P1   = SET1 + SYNCX + 1;
    localparam int LAT0 = S + N * P0;
    localparam int LAT1 = S + N * P1;

    logic clk = 1'b0;
    logic rst0, rst1;
    logic [N-1:0] vin0, vin1;
    bit done1 = 1'b0;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    sar_adc_ctrl_if #(.N_BITS(N)) if0 ();
    sar_adc_ctrl_if #(.N_BITS(N)) if1 ();

    assign if0.cmp = (vin0 >= if0.dac_code);
    assign if1.cmp = (vin1 >= if1.dac_code);

    sar_adc_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(SET0)) u0 (
        .clk(clk), .reset(rst0), .bus(if0));
    sar_adc_ctrl #(.N_BITS(N), .SAMPLE_CYCLES(S), .SETTLE_CYCLES(SET1)) u1 (
        .clk(clk), .reset(rst1), .bus(if1));

    task automatic chk(input string name, input int inst, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s inst=%0d got=%h want=%h at %0t", name, inst, got, exp, $time);
        end
    endtask

    // Trial b (0 = MSB): bits of vin above the trial bit, plus the trial bit itself.
    function automatic logic [N-1:0] trial(input logic [N-1:0] v, input int b);
        int w, hi;
        w  = 1 << (N - b);
        hi = (int'(v) / w) * w;
        return N'(hi + (1 << (N - 1 - b)));
    endfunction

    // Conversion model: elapsed cycles since the accepting edge define every output.
    bit           m_init[2], m_busy[2], m_valid[2];
    int           m_t[2], hs_cnt[2];
    logic [N-1:0] m_vin[2], m_out[2];

    always @(posedge clk) begin
        logic         rs[2], st[2], rd[2], ob[2], osh[2], ov[2];
        logic [N-1:0] vv[2], odac[2], od[2], edac;
        int           lat, p;
        rs[0] = rst0;       rs[1] = rst1;
        st[0] = if0.start;  st[1] = if1.start;
        rd[0] = if0.out_ready; rd[1] = if1.out_ready;
        vv[0] = vin0;       vv[1] = vin1;
        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? LAT0 : LAT1;
            if (!rs[i]) begin
                m_init[i] = 1'b1; m_busy[i] = 1'b0; m_valid[i] = 1'b0; m_t[i] = 0;
            end else if (!m_init[i]) begin
            end else if (!m_busy[i]) begin
                if (st[i]) begin m_busy[i] = 1'b1; m_t[i] = 0; m_vin[i] = vv[i]; end
            end else if (m_valid[i]) begin
                if (rd[i]) begin m_busy[i] = 1'b0; m_valid[i] = 1'b0; hs_cnt[i]++; end
            end else begin
                m_t[i]++;
                if (m_t[i] == lat) begin m_valid[i] = 1'b1; m_out[i] = m_vin[i]; end
            end
        end
        #1;
        ob[0] = if0.busy; osh[0] = if0.sample_hold; odac[0] = if0.dac_code;
        ov[0] = if0.out_valid; od[0] = if0.out_data;
        ob[1] = if1.busy; osh[1] = if1.sample_hold; odac[1] = if1.dac_code;
        ov[1] = if1.out_valid; od[1] = if1.out_data;
        for (int i = 0; i < 2; i++) begin
            if (m_init[i]) begin
                p = (i == 0) ? P0 : P1;
                edac = '0;
                if (m_busy[i] && !m_valid[i] && m_t[i] >= S)
                    edac = trial(m_vin[i], (m_t[i] - S) / p);
                chk("busy", i, 32'(ob[i]), 32'(m_busy[i]));
                chk("sample_hold", i, 32'(osh[i]),
                    32'(m_busy[i] && !m_valid[i] && m_t[i] < S));
                chk("dac_code", i, 32'(odac[i]), 32'(edac));
                chk("out_valid", i, 32'(ov[i]), 32'(m_valid[i]));
                if (m_valid[i]) chk("out_data", i, 32'(od[i]), 32'(m_out[i]));
            end
        end
    end

    task automatic run_conv(input logic [N-1:0] v, output int lat, output logic [N-1:0] data,
                            output int sh_cnt, output logic [N-1:0] d0, d1, d2);
        lat = -1; data = '0; sh_cnt = 0; d0 = '0; d1 = '0; d2 = '0;
        @(negedge clk); vin0 = v; if0.start = 1'b1; if0.out_ready = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        for (int t = 0; t < 200 && lat < 0; t++) begin
            if (if0.sample_hold) sh_cnt++;
            if (t == S)          d0 = if0.dac_code;
            if (t == S + P0)     d1 = if0.dac_code;
            if (t == S + 2 * P0) d2 = if0.dac_code;
            if (if0.out_valid) begin lat = t; data = if0.out_data; end
            else @(negedge clk);
        end
        @(negedge clk);
    endtask

    initial begin
        int           lat, sh, nr, prev, seen;
        int           rises[3];
        logic [N-1:0] data, d0, d1, d2;
        rst0 = 1'b0; vin0 = '0; if0.start = 1'b0; if0.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 0, 32'(if0.busy), 0);
        chk("rst_sh", 0, 32'(if0.sample_hold), 0);
        chk("rst_dac", 0, 32'(if0.dac_code), 0);
        chk("rst_data", 0, 32'(if0.out_data), 0);
        chk("rst_valid", 0, 32'(if0.out_valid), 0);
        rst0 = 1'b1;
        @(negedge clk);

        run_conv(10'h2A5, lat, data, sh, d0, d1, d2);
        chk("conv_2a5", 0, 32'(data), 32'h2A5);
        chk("latency", 0, lat, LAT_LIT);
        chk("trial0", 0, 32'(d0), 32'h200);
        chk("trial1", 0, 32'(d1), 32'h300);
        chk("trial2", 0, 32'(d2), 32'h280);
        chk("sh_len", 0, sh, 4);
        run_conv(10'h000, lat, data, sh, d0, d1, d2);
        chk("conv_000", 0, 32'(data), 32'h000);
        chk("sh_len_000", 0, sh, 4);
        run_conv(10'h3FF, lat, data, sh, d0, d1, d2);
        chk("conv_3ff", 0, 32'(data), 32'h3FF);
        chk("sh_len_3ff", 0, sh, 4);

        // Backpressure: result held, new vin and start pulses ignored.
        @(negedge clk); vin0 = 10'h155; if0.start = 1'b1; if0.out_ready = 1'b0;
        @(negedge clk); if0.start = 1'b0;
        for (int t = 0; t < 200 && !if0.out_valid; t++) @(negedge clk);
        chk("bp_valid_rise", 0, 32'(if0.out_valid), 1);
        for (int k = 0; k < 20; k++) begin
            chk("bp_hold_data", 0, 32'(if0.out_data), 32'h155);
            chk("bp_hold_valid", 0, 32'(if0.out_valid), 1);
            vin0 = 10'h0AA;
            if0.start = (k == 3 || k == 10 || k == 11);
            @(negedge clk);
        end
        if0.start = 1'b0; if0.out_ready = 1'b1;
        @(negedge clk); if0.out_ready = 1'b0;
        chk("bp_after_hs_valid", 0, 32'(if0.out_valid), 0);
        chk("bp_after_hs_busy", 0, 32'(if0.busy), 0);
        @(negedge clk);
        chk("bp_no_queued_start", 0, 32'(if0.busy), 0);
        run_conv(10'h0AA, lat, data, sh, d0, d1, d2);
        chk("bp_next_conv", 0, 32'(data), 32'h0AA);

        // Abort while bit index 5 is on trial.
        @(negedge clk); vin0 = 10'h3C3; if0.start = 1'b1; if0.out_ready = 1'b1;
        @(negedge clk); if0.start = 1'b0;
        repeat (S + 4 * P0) @(negedge clk);
        chk("abort_trial_idx5", 0, 32'(if0.dac_code), 32'h3E0);
        rst0 = 1'b0;
        @(negedge clk); rst0 = 1'b1;
        chk("abort_busy", 0, 32'(if0.busy), 0);
        chk("abort_dac", 0, 32'(if0.dac_code), 0);
        chk("abort_data", 0, 32'(if0.out_data), 0);
        seen = 0;
        repeat (LAT0 + 10) begin
            if (if0.out_valid) seen++;
            @(negedge clk);
        end
        chk("abort_no_valid", 0, seen, 0);
        run_conv(10'h1E7, lat, data, sh, d0, d1, d2);
        chk("post_abort_conv", 0, 32'(data), 32'h1E7);

        // start held high: one DONE cycle plus one IDLE cycle between conversions.
        @(negedge clk); vin0 = 10'h321; if0.start = 1'b1; if0.out_ready = 1'b1;
        nr = 0; prev = 0;
        for (int k = 0; k < 3 * (LAT0 + 2) + 50 && nr < 3; k++) begin
            if (if0.out_valid && prev == 0) begin
                rises[nr] = k;
                chk("rep_data", 0, 32'(if0.out_data), 32'h321);
                nr++;
            end
            prev = int'(if0.out_valid);
            if (nr < 3) @(negedge clk);
        end
        if0.start = 1'b0;
        chk("rep_count", 0, nr, 3);
        if (nr == 3) begin
            chk("rep_period1", 0, rises[1] - rises[0], LAT0 + 2);
            chk("rep_period2", 0, rises[2] - rises[1], LAT0 + 2);
        end
        repeat (4) @(negedge clk);

        while (!done1) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Zero-settle instance: random vin/start/ready until 1000 samples are handed over.
    initial begin
        int cyc;
        rst1 = 1'b0; vin1 = '0; if1.start = 1'b0; if1.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst1 = 1'b1;
        cyc = 0;
        while (hs_cnt[1] < 1000 && cyc < 70000) begin
            @(negedge clk);
            cyc++;
            if1.start     = ($urandom_range(0, 3) != 0);
            if1.out_ready = ($urandom_range(0, 3) != 0);
            if (!if1.busy) vin1 = N'($urandom_range(0, (1 << N) - 1));
        end
        chk("rand_samples", 1, hs_cnt[1] >= 1000, 1);
        if1.start = 1'b0;
        done1 = 1'b1;
    end
endmodule
